// File: rtl/avmm2axi4l_bridge_if.sv
// Avalon-MM host port and AXI4-Lite master port of avmm2axi4l_bridge in one bundle.
// slave: the bridge's view (Avalon slave / AXI master); master: host plus AXI target side.
interface avmm2axi4l_bridge_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] avs_address;
  logic                  avs_read;
  logic                  avs_write;
  logic [DATA_WIDTH-1:0] avs_writedata;
  logic [STRB_WIDTH-1:0] avs_byteenable;
  logic                  avs_waitrequest;
  logic [DATA_WIDTH-1:0] avs_readdata;
  logic                  avs_readdatavalid;
  logic                  avs_writeresponsevalid;
  logic [1:0]            avs_response;

  logic [ADDR_WIDTH-1:0] axi_master_awaddr;
  logic [2:0]            axi_master_awprot;
  logic                  axi_master_awvalid;
  logic                  axi_master_awready;
  logic [DATA_WIDTH-1:0] axi_master_wdata;
  logic [STRB_WIDTH-1:0] axi_master_wstrb;
  logic                  axi_master_wvalid;
  logic                  axi_master_wready;
  logic [1:0]            axi_master_bresp;
  logic                  axi_master_bvalid;
  logic                  axi_master_bready;
  logic [ADDR_WIDTH-1:0] axi_master_araddr;
  logic [2:0]            axi_master_arprot;
  logic                  axi_master_arvalid;
  logic                  axi_master_arready;
  logic [DATA_WIDTH-1:0] axi_master_rdata;
  logic [1:0]            axi_master_rresp;
  logic                  axi_master_rvalid;
  logic                  axi_master_rready;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_waitrequest, avs_readdata, avs_readdatavalid, avs_writeresponsevalid, avs_response,
    output axi_master_awaddr, axi_master_awprot, axi_master_awvalid,
    input  axi_master_awready,
    output axi_master_wdata, axi_master_wstrb, axi_master_wvalid,
    input  axi_master_wready,
    input  axi_master_bresp, axi_master_bvalid,
    output axi_master_bready,
    output axi_master_araddr, axi_master_arprot, axi_master_arvalid,
    input  axi_master_arready,
    input  axi_master_rdata, axi_master_rresp, axi_master_rvalid,
    output axi_master_rready
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid, avs_writeresponsevalid, avs_response,
    input  axi_master_awaddr, axi_master_awprot, axi_master_awvalid,
    output axi_master_awready,
    input  axi_master_wdata, axi_master_wstrb, axi_master_wvalid,
    output axi_master_wready,
    output axi_master_bresp, axi_master_bvalid,
    input  axi_master_bready,
    input  axi_master_araddr, axi_master_arprot, axi_master_arvalid,
    output axi_master_arready,
    output axi_master_rdata, axi_master_rresp, axi_master_rvalid,
    input  axi_master_rready
  );
endinterface

// File: rtl/avmm2axi4l_bridge.sv
// Avalon-MM slave to AXI4-Lite master bridge, one transaction outstanding at a time.
// Define AVMM2AXI4L_TIMEOUT_EN to add the response timeout (TIMEOUT_CYCLES) and idle response draining.
module avmm2axi4l_bridge #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic softreset,
  avmm2axi4l_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_strb;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_resp;
  logic                  r_waitrequest;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rdv;
  logic                  r_wrv;

  logic w_accept;
  logic w_aw_done;
  logic w_w_done;
  logic w_timeout;

  assign w_accept  = (r_state == IDLE) & ~r_waitrequest & (bus.avs_read | bus.avs_write);
  assign w_aw_done = ~r_awvalid | bus.axi_master_awready;
  assign w_w_done  = ~r_wvalid | bus.axi_master_wready;

`ifdef AVMM2AXI4L_TIMEOUT_EN
  localparam int   CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic IDLE_READY = 1'b1;

  logic [CNT_W-1:0] r_cnt;

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Response wait counter; zero on entry to either response state.
  always_ff @(posedge clk or posedge softreset) begin
    if (softreset) begin
      r_cnt <= '0;
    end else if ((r_state == WR_RESP) || (r_state == RD_RESP)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end
`else
  localparam logic IDLE_READY = 1'b0;

  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 32'sd0);
`endif

  // Transaction FSM; every bus-facing output is a register driven here.
  always_ff @(posedge clk or posedge softreset) begin
    if (softreset) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_strb        <= '0;
      r_rdata       <= '0;
      r_resp        <= 2'b00;
      r_waitrequest <= 1'b1;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rdv         <= 1'b0;
      r_wrv         <= 1'b0;
    end else begin
      r_rdv <= 1'b0;
      r_wrv <= 1'b0;
      case (r_state)
        IDLE: begin
          r_rready <= IDLE_READY;
          r_bready <= IDLE_READY;
          // waitrequest is still high for the cycle holding the completion pulse
          if (r_waitrequest) begin
            r_waitrequest <= 1'b0;
          end else if (w_accept) begin
            r_waitrequest <= 1'b1;
            r_addr        <= bus.avs_address;
            r_wdata       <= bus.avs_writedata;
            r_strb        <= bus.avs_byteenable;
            r_rready      <= 1'b0;
            r_bready      <= 1'b0;
            if (bus.avs_write) begin
              r_state   <= WR_REQ;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= RD_REQ;
              r_arvalid <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (w_aw_done && w_w_done) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= WR_RESP;
          end else begin
            if (bus.axi_master_awready) r_awvalid <= 1'b0;
            if (bus.axi_master_wready)  r_wvalid  <= 1'b0;
          end
        end
        WR_RESP: begin
          if (bus.axi_master_bvalid) begin
            r_resp   <= bus.axi_master_bresp;
            r_wrv    <= 1'b1;
            r_bready <= IDLE_READY;
            r_state  <= IDLE;
          end else if (w_timeout) begin
            r_resp   <= 2'b11;
            r_wrv    <= 1'b1;
            r_bready <= IDLE_READY;
            r_state  <= IDLE;
          end
        end
        RD_REQ: begin
          if (bus.axi_master_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (bus.axi_master_rvalid) begin
            r_rdata  <= bus.axi_master_rdata;
            r_resp   <= bus.axi_master_rresp;
            r_rdv    <= 1'b1;
            r_rready <= IDLE_READY;
            r_state  <= IDLE;
          end else if (w_timeout) begin
            r_rdata  <= {DATA_WIDTH{1'b1}};
            r_resp   <= 2'b11;
            r_rdv    <= 1'b1;
            r_rready <= IDLE_READY;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_waitrequest <= 1'b1;
          r_awvalid     <= 1'b0;
          r_wvalid      <= 1'b0;
          r_arvalid     <= 1'b0;
          r_bready      <= 1'b0;
          r_rready      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.avs_waitrequest        = r_waitrequest;
  assign bus.avs_readdata           = r_rdata;
  assign bus.avs_readdatavalid      = r_rdv;
  assign bus.avs_writeresponsevalid = r_wrv;
  assign bus.avs_response           = r_resp;

  assign bus.axi_master_awaddr  = r_addr;
  assign bus.axi_master_awprot  = 3'b000;
  assign bus.axi_master_awvalid = r_awvalid;
  assign bus.axi_master_wdata   = r_wdata;
  assign bus.axi_master_wstrb   = r_strb;
  assign bus.axi_master_wvalid  = r_wvalid;
  assign bus.axi_master_bready  = r_bready;
  assign bus.axi_master_araddr  = r_addr;
  assign bus.axi_master_arprot  = 3'b000;
  assign bus.axi_master_arvalid = r_arvalid;
  assign bus.axi_master_rready  = r_rready;

endmodule

// File: tb/tb_avmm2axi4l_bridge.sv
// Self-checking bench for avmm2axi4l_bridge: vector table, random traffic against a memory model,
// reset-in-flight sequence and (with AVMM2AXI4L_TIMEOUT_EN) the response timeout.
module tb_avmm2axi4l_bridge;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic softreset;
  always #5 clk = ~clk;

  avmm2axi4l_bridge_if bus ();

  avmm2axi4l_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .softreset (softreset),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_wr;
    bit          both;
    bit          from_mem;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          aw_dly;
    int          w_dly;
    int          ar_dly;
    int          rsp_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          exp_lat;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } txn_t;

  logic [31:0] ref_mem [logic [15:0]];
  logic [31:0] slv_mem [logic [15:0]];
  logic [31:0] last_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_default(input logic [15:0] a);
    return {16'hC0DE, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  // Completion cycle counted from acceptance: one cycle to issue, one to enter the response
  // state, one to pulse, plus every wait cycle the AXI side inserts.
  function automatic int model_latency(input txn_t t);
    if (t.is_wr) return 3 + ((t.aw_dly > t.w_dly) ? t.aw_dly : t.w_dly) + t.rsp_dly;
    return 3 + t.ar_dly + t.rsp_dly;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.is_wr    = ($urandom_range(0, 1) == 1);
    t.both     = t.is_wr && ($urandom_range(0, 3) == 0);
    t.from_mem = 1'b1;
    t.addr     = 16'h0100 + 16'(4 * $urandom_range(0, 3));
    t.wdata    = $urandom;
    t.be       = 4'($urandom_range(0, 15));
    t.aw_dly   = $urandom_range(0, 3);
    t.w_dly    = $urandom_range(0, 3);
    t.ar_dly   = $urandom_range(0, 3);
    t.rsp_dly  = $urandom_range(0, 3);
    t.resp     = 2'($urandom_range(0, 3));
    t.rdata    = 32'h0;
    t.exp_lat  = model_latency(t);
    t.exp_resp = t.resp;
    t.exp_rdata = t.is_wr ? last_rd : ref_read(t.addr);
    return t;
  endfunction

  task automatic slave_idle();
    bus.axi_master_awready = 1'b0;
    bus.axi_master_wready  = 1'b0;
    bus.axi_master_arready = 1'b0;
    bus.axi_master_bvalid  = 1'b0;
    bus.axi_master_bresp   = 2'b00;
    bus.axi_master_rvalid  = 1'b0;
    bus.axi_master_rresp   = 2'b00;
    bus.axi_master_rdata   = 32'h0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.avs_waitrequest && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " waitrequest_low"}, bus.avs_waitrequest, 1'b0);
  endtask

  // Drives one Avalon command and plays the AXI target; entered and left on a falling edge.
  task automatic run_txn(input txn_t t, input string tag);
    int k = 0, pulse_k = -1, npulse = 0, viol = 0;
    int aw_k = -1, w_k = -1, aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit aw_done = 0, w_done = 0, ar_done = 0, rsp_sent = 0;
    logic [1:0]  got_resp  = 2'b00;
    logic [31:0] got_rdata = 32'h0;
    logic [15:0] got_addr  = 16'h0;
    logic [31:0] got_wdata = 32'h0;
    logic [3:0]  got_strb  = 4'h0;
    logic [31:0] srd;

    wait_ready(tag);
    if (bus.avs_waitrequest) return;
    srd = t.from_mem ? (slv_mem.exists(t.addr) ? slv_mem[t.addr] : mem_default(t.addr)) : t.rdata;
    bus.avs_address    = t.addr;
    bus.avs_write      = t.is_wr;
    bus.avs_read       = !t.is_wr || t.both;
    bus.avs_writedata  = t.wdata;
    bus.avs_byteenable = t.be;
    while (k < 80) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      bus.avs_read  = 1'b0;
      bus.avs_write = 1'b0;
      slave_idle();
      if (bus.avs_readdatavalid || bus.avs_writeresponsevalid) begin
        npulse++;
        if (pulse_k < 0) begin
          pulse_k   = k;
          got_resp  = bus.avs_response;
          got_rdata = bus.avs_readdata;
        end
      end
      if ((t.is_wr && bus.avs_readdatavalid) || (!t.is_wr && bus.avs_writeresponsevalid)) viol++;
      if ((pulse_k < 0 || k == pulse_k) && !bus.avs_waitrequest) viol++;
      if (pulse_k > 0 && k == pulse_k + 1) begin
        check({tag, " waitrequest_release"}, bus.avs_waitrequest, 1'b0);
        break;
      end
      if (t.is_wr) begin
        if (bus.axi_master_arvalid) viol++;
        if (bus.axi_master_awvalid) begin
          if (aw_done) viol++;
          else if (aw_cnt >= t.aw_dly) begin
            bus.axi_master_awready = 1'b1;
            aw_done = 1;
            aw_k = k;
            got_addr = bus.axi_master_awaddr;
          end else aw_cnt++;
        end
        if (bus.axi_master_wvalid) begin
          if (w_done) viol++;
          else if (w_cnt >= t.w_dly) begin
            bus.axi_master_wready = 1'b1;
            w_done = 1;
            w_k = k;
            got_wdata = bus.axi_master_wdata;
            got_strb  = bus.axi_master_wstrb;
          end else w_cnt++;
        end
        if (bus.axi_master_bready && aw_done && w_done && !rsp_sent) begin
          if (r_cnt >= t.rsp_dly) begin
            bus.axi_master_bvalid = 1'b1;
            bus.axi_master_bresp  = t.resp;
            rsp_sent = 1;
          end else r_cnt++;
        end
      end else begin
        if (bus.axi_master_awvalid || bus.axi_master_wvalid) viol++;
        if (bus.axi_master_arvalid) begin
          if (ar_done) viol++;
          else if (ar_cnt >= t.ar_dly) begin
            bus.axi_master_arready = 1'b1;
            ar_done = 1;
            got_addr = bus.axi_master_araddr;
          end else ar_cnt++;
        end
        if (bus.axi_master_rready && ar_done && !rsp_sent) begin
          if (r_cnt >= t.rsp_dly) begin
            bus.axi_master_rvalid = 1'b1;
            bus.axi_master_rresp  = t.resp;
            bus.axi_master_rdata  = srd;
            rsp_sent = 1;
          end else r_cnt++;
        end
      end
    end
    slave_idle();
    check({tag, " latency"}, pulse_k, t.exp_lat);
    check({tag, " pulses"}, npulse, 1);
    check({tag, " response"}, got_resp, t.exp_resp);
    check({tag, " addr"}, got_addr, t.addr);
    check({tag, " protocol"}, viol, 0);
    if (t.is_wr) begin
      check({tag, " wdata"}, got_wdata, t.wdata);
      check({tag, " wstrb"}, got_strb, t.be);
      check({tag, " aw_cycle"}, aw_k, 1 + t.aw_dly);
      check({tag, " w_cycle"}, w_k, 1 + t.w_dly);
      check({tag, " readdata_hold"}, bus.avs_readdata, t.exp_rdata);
      slv_mem[got_addr] = merge(slv_mem.exists(got_addr) ? slv_mem[got_addr] : mem_default(got_addr),
                                got_wdata, got_strb);
    end else begin
      check({tag, " readdata"}, got_rdata, t.exp_rdata);
    end
  endtask

  task automatic apply(input txn_t t, input string tag);
    run_txn(t, tag);
    if (t.is_wr) ref_mem[t.addr] = merge(ref_read(t.addr), t.wdata, t.be);
    else last_rd = t.exp_rdata;
  endtask

  txn_t vec [7];
  txn_t tr;
  int   np;

  initial begin
    softreset = 1'b1;
    bus.avs_address = 16'h0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    bus.avs_writedata = 32'h0; bus.avs_byteenable = 4'h0;
    slave_idle();
    last_rd = 32'h0;

    //         wr   both from addr      wdata         be     aw w ar rsp resp   rdata         lat rresp  exp_rdata
    vec[0] = '{1'b0, 1'b0, 1'b0, 16'h0010, 32'h0,        4'hF,  0, 0, 0, 0, 2'b00, 32'hA5A5_0001, 3, 2'b00, 32'hA5A5_0001};
    vec[1] = '{1'b1, 1'b0, 1'b0, 16'h0020, 32'h1234_5678, 4'h3, 4, 0, 0, 0, 2'b00, 32'h0,         7, 2'b00, 32'hA5A5_0001};
    vec[2] = '{1'b1, 1'b1, 1'b0, 16'h0030, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0,         3, 2'b00, 32'hA5A5_0001};
    vec[3] = '{1'b0, 1'b0, 1'b0, 16'h0014, 32'h0,        4'hF,  0, 0, 0, 0, 2'b10, 32'h0BAD_BEEF, 3, 2'b10, 32'h0BAD_BEEF};
    vec[4] = '{1'b1, 1'b0, 1'b0, 16'h0024, 32'h55AA_55AA, 4'hC, 1, 3, 0, 2, 2'b11, 32'h0,         8, 2'b11, 32'h0BAD_BEEF};
    vec[5] = '{1'b0, 1'b0, 1'b0, 16'h0018, 32'h0,        4'hF,  0, 0, 2, 3, 2'b01, 32'h7654_3210, 8, 2'b01, 32'h7654_3210};
    vec[6] = '{1'b1, 1'b0, 1'b0, 16'h0028, 32'hDEAD_BEEF, 4'hF, 2, 2, 0, 1, 2'b00, 32'h0,         6, 2'b00, 32'h7654_3210};

    repeat (3) @(negedge clk);
    check("reset waitrequest", bus.avs_waitrequest, 1'b1);
    check("reset pulses", {bus.avs_readdatavalid, bus.avs_writeresponsevalid}, 2'b00);
    check("reset valids_readys", {bus.axi_master_awvalid, bus.axi_master_wvalid, bus.axi_master_arvalid,
                                  bus.axi_master_bready, bus.axi_master_rready}, 5'b0);
    check("reset readdata", bus.avs_readdata, 32'h0);
    check("reset response", bus.avs_response, 2'b00);
    softreset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      apply(vec[i], $sformatf("vec%0d", i));
      ref_mem[vec[i].addr] = slv_mem.exists(vec[i].addr) ? ref_read(vec[i].addr) : ref_read(vec[i].addr);
    end

    for (int i = 0; i < 40; i++) begin
      tr = rand_txn();
      apply(tr, $sformatf("rnd%0d", i));
    end

    // softreset while the read waits in RD_RESP
    wait_ready("rst_seq");
    bus.avs_address = 16'h0040;
    bus.avs_read    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.avs_read = 1'b0;
    check("rst_seq arvalid", bus.axi_master_arvalid, 1'b1);
    bus.axi_master_arready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.axi_master_arready = 1'b0;
    check("rst_seq rready", bus.axi_master_rready, 1'b1);
    softreset = 1'b1;
    #1;
    check("rst_seq waitrequest", bus.avs_waitrequest, 1'b1);
    check("rst_seq valids_readys", {bus.axi_master_awvalid, bus.axi_master_wvalid, bus.axi_master_arvalid,
                                    bus.axi_master_bready, bus.axi_master_rready}, 5'b0);
    check("rst_seq readdata", bus.avs_readdata, 32'h0);
    check("rst_seq response", bus.avs_response, 2'b00);
    np = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.avs_readdatavalid || bus.avs_writeresponsevalid) np++;
    end
    softreset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.avs_readdatavalid || bus.avs_writeresponsevalid) np++;
    end
    check("rst_seq no_pulse", np, 0);
    last_rd = 32'h0;
    tr = '{1'b0, 1'b0, 1'b0, 16'h0044, 32'h0, 4'hF, 0, 0, 0, 0, 2'b00, 32'h1357_9BDF, 3, 2'b00, 32'h1357_9BDF};
    apply(tr, "post_rst");

`ifdef AVMM2AXI4L_TIMEOUT_EN
    // rvalid never arrives: pulse TO cycles after entering RD_RESP (entered at cycle 2)
    tr = '{1'b0, 1'b0, 1'b0, 16'h0050, 32'h0, 4'hF, 0, 0, 0, 1000, 2'b00, 32'h0, 2 + TO, 2'b11, 32'hFFFF_FFFF};
    apply(tr, "timeout");
    check("timeout idle_rready", bus.axi_master_rready, 1'b1);
    bus.axi_master_rvalid = 1'b1;
    bus.axi_master_rdata  = 32'h0000_2468;
    np = 0;
    repeat (4) begin
      @(negedge clk);
      bus.axi_master_rvalid = 1'b0;
      if (bus.avs_readdatavalid || bus.avs_writeresponsevalid) np++;
    end
    check("timeout stray_dropped", np, 0);
    check("timeout readdata_kept", bus.avs_readdata, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
